// File: rtl/dmem_request_unit.sv
// Memory-stage initiator for the 64-bit data port: one outstanding access over
// req/gnt/rvalid, store lane replication, byte enables and pipeline stall.
module dmem_request_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        squash_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [3:0]  mem_width_1h_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [7:0]  dmem_be_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic [2:0]  byte_addr_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  byte_q, byte_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic        access;
  logic        bad_access;
  logic        accept;
  logic [2:0]  a;
  logic [7:0]  be_calc;
  logic [63:0] lane_calc;

  // Width decode: enables, replicated store lane and alignment/one-hot check.
  always_comb begin
    a          = addr_i[2:0];
    be_calc    = 8'h00;
    lane_calc  = 64'h0;
    bad_access = 1'b0;
    case (mem_width_1h_i)
      4'b0001: begin
        be_calc   = 8'h01 << a;
        lane_calc = {8{wdata_i[7:0]}};
      end
      4'b0010: begin
        be_calc    = 8'h03 << {a[2:1], 1'b0};
        lane_calc  = {4{wdata_i[15:0]}};
        bad_access = a[0];
      end
      4'b0100: begin
        be_calc    = 8'h0F << {a[2], 2'b00};
        lane_calc  = {2{wdata_i[31:0]}};
        bad_access = |a[1:0];
      end
      4'b1000: begin
        be_calc    = 8'hFF;
        lane_calc  = wdata_i;
        bad_access = |a;
      end
      default: bad_access = 1'b1;
    endcase
  end

  assign access       = valid_i & (mem_rd_i | mem_wr_i) & ~squash_i;
  assign misaligned_o = access & bad_access;
  assign accept       = (state_q == IDLE) & access & ~bad_access;
  assign stall_o      = accept | (state_q == REQ) | ((state_q == RESP) & ~dmem_rvalid_i);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_wr_i;
          addr_d  = {addr_i[63:3], 3'b000};
          be_d    = be_calc;
          wdata_d = mem_wr_i ? lane_calc : 64'h0;
          byte_d  = a;
        end
      end
      REQ: begin
        // Grant takes priority over a same-cycle squash.
        if (dmem_gnt_i) begin
          req_d  = 1'b0;
          drop_d = 1'b0;
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RESP;
          end
        end else if (squash_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          done_d  = ~drop_q & ~squash_i;
          drop_d  = 1'b0;
        end else if (squash_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'h0;
      be_q    <= 8'h00;
      wdata_q <= 64'h0;
      byte_q  <= 3'd0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign byte_addr_o  = byte_q;

endmodule

// File: tb/tb_dmem_request_unit.sv
// Bench for dmem_request_unit: directed table, corner sequences and randomized
// accesses checked against a transaction-level model of the handshake.
module tb_dmem_request_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, squash_i, mem_rd_i, mem_wr_i;
  logic [63:0] addr_i, wdata_i;
  logic [3:0]  mem_width_1h_i;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        stall_o, done_o, misaligned_o;
  logic [2:0]  byte_addr_o;

  always #5 clk_i = ~clk_i;

  dmem_request_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .squash_i(squash_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_width_1h_i(mem_width_1h_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .stall_o(stall_o),
    .done_o(done_o), .misaligned_o(misaligned_o), .byte_addr_o(byte_addr_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [2:0] last_byte = 3'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b", name, got, exp);
  endtask

  // ---- reference model: access size in bytes, 0 for an illegal width ----
  function automatic int size_of(input logic [3:0] w);
    case (w)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_mis(input logic [3:0] w, input logic [63:0] a);
    int s = size_of(w);
    if (s == 0) return 1'b1;
    return (int'(a[2:0]) % s) != 0;
  endfunction

  function automatic logic [7:0] model_be(input logic [3:0] w, input logic [63:0] a);
    logic [7:0] r = 8'h00;
    int off = int'(a[2:0]);
    int s = size_of(w);
    for (int i = 0; i < 8; i++) r[i] = (i >= off) && (i < off + s);
    return r;
  endfunction

  function automatic logic [63:0] model_wd(input bit wr, input logic [3:0] w, input logic [63:0] d);
    logic [63:0] r = 64'h0;
    int s = size_of(w);
    if (!wr || s == 0) return 64'h0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  // One whole access. Called at (or just after) a falling edge; returns just
  // after the falling edge of the done cycle so the next access goes back-to-back.
  // gd: grant delay in REQ cycles; rdl: rvalid delay in RESP cycles;
  // sqq/sqr: cycle index of a squash in REQ/RESP, -1 for none.
  task automatic do_access(input bit wr, input logic [3:0] w, input logic [63:0] a,
                           input logic [63:0] d, input int gd, input int rdl,
                           input int sqq, input int sqr, input bit emis,
                           input logic [63:0] eaddr, input logic [7:0] ebe,
                           input logic [63:0] ewd);
    bit aborted = 1'b0;
    valid_i = 1'b1; mem_rd_i = !wr; mem_wr_i = wr;
    addr_i = a; wdata_i = d; mem_width_1h_i = w;
    #1;
    check1("misaligned", misaligned_o, emis);
    check1("stall_accept", stall_o, !emis);
    @(posedge clk_i); @(negedge clk_i);
    valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    if (emis) begin
      #1;
      check1("no_req_misaligned", dmem_req_o, 1'b0);
      check1("stall_misaligned", stall_o, 1'b0);
      check("byte_addr_hold", 64'(byte_addr_o), 64'(last_byte));
      return;
    end
    last_byte = a[2:0];
    for (int c = 0; c <= gd; c++) begin
      dmem_gnt_i = (c == gd);
      squash_i = (c == sqq);
      dmem_rvalid_i = 1'($urandom_range(0, 1));
      #1;
      check1("req_held", dmem_req_o, 1'b1);
      check1("we", dmem_we_o, wr);
      check("addr", dmem_addr_o, eaddr);
      check("be", 64'(dmem_be_o), 64'(ebe));
      check("wdata", dmem_wdata_o, ewd);
      check("byte_addr", 64'(byte_addr_o), 64'(a[2:0]));
      check1("stall_req", stall_o, 1'b1);
      check1("done_in_req", done_o, 1'b0);
      @(posedge clk_i); @(negedge clk_i);
      dmem_gnt_i = 1'b0; squash_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (c == sqq && c != gd) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      #1;
      check1("req_after_squash", dmem_req_o, 1'b0);
      check1("done_after_squash", done_o, 1'b0);
      check1("stall_after_squash", stall_o, 1'b0);
      return;
    end
    if (wr) begin
      #1;
      check1("store_done", done_o, 1'b1);
      check1("req_after_store", dmem_req_o, 1'b0);
      check1("stall_after_store", stall_o, 1'b0);
      return;
    end
    for (int c = 0; c <= rdl; c++) begin
      dmem_rvalid_i = (c == rdl);
      squash_i = (c == sqr);
      dmem_gnt_i = 1'($urandom_range(0, 1));
      #1;
      check1("req_in_resp", dmem_req_o, 1'b0);
      check1("stall_resp", stall_o, !(c == rdl));
      check1("done_in_resp", done_o, 1'b0);
      @(posedge clk_i); @(negedge clk_i);
      dmem_gnt_i = 1'b0; squash_i = 1'b0; dmem_rvalid_i = 1'b0;
    end
    #1;
    check1("load_done", done_o, !(sqr >= 0 && sqr <= rdl));
    check1("req_after_load", dmem_req_o, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  w;
    logic [63:0] a;
    logic [63:0] d;
    int          gd, rdl, sqq, sqr;
    bit          emis;
    logic [63:0] eaddr;
    logic [7:0]  ebe;
    logic [63:0] ewd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; squash_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    addr_i = 64'h0; wdata_i = 64'h0; mem_width_1h_i = 4'b0001;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;

    vecs[0]  = '{1, 4'b0001, 64'h1005, 64'hAB, 0, 0, -1, -1, 0, 64'h1000, 8'h20, 64'hABABABABABABABAB};
    vecs[1]  = '{0, 4'b0100, 64'h2004, 64'h0, 3, 1, -1, -1, 0, 64'h2000, 8'hF0, 64'h0};
    vecs[2]  = '{0, 4'b0010, 64'h3003, 64'h0, 0, 0, -1, -1, 1, 64'h0, 8'h00, 64'h0};
    vecs[3]  = '{1, 4'b1000, 64'h3004, 64'h5, 0, 0, -1, -1, 1, 64'h0, 8'h00, 64'h0};
    vecs[4]  = '{1, 4'b1000, 64'h40, 64'hDEADBEEF01234567, 0, 0, -1, -1, 0, 64'h40, 8'hFF, 64'hDEADBEEF01234567};
    vecs[5]  = '{0, 4'b0001, 64'h47, 64'h0, 0, 0, -1, -1, 0, 64'h40, 8'h80, 64'h0};
    vecs[6]  = '{0, 4'b0010, 64'h106, 64'h0, 3, 0, 1, -1, 0, 64'h100, 8'hC0, 64'h0};
    vecs[7]  = '{0, 4'b1000, 64'h208, 64'h0, 0, 2, -1, 0, 0, 64'h208, 8'hFF, 64'h0};
    vecs[8]  = '{1, 4'b0100, 64'h30C, 64'h1122334455667788, 1, 0, 1, -1, 0, 64'h308, 8'hF0, 64'h5566778855667788};
    vecs[9]  = '{1, 4'b0011, 64'h10, 64'h1, 0, 0, -1, -1, 1, 64'h0, 8'h00, 64'h0};
    vecs[10] = '{1, 4'b0010, 64'h52, 64'hBEEF, 2, 0, -1, -1, 0, 64'h50, 8'h0C, 64'hBEEFBEEFBEEFBEEF};

    #1;
    check1("rst_req", dmem_req_o, 1'b0);
    check1("rst_we", dmem_we_o, 1'b0);
    check("rst_addr", dmem_addr_o, 64'h0);
    check("rst_be", 64'(dmem_be_o), 64'h0);
    check("rst_wdata", dmem_wdata_o, 64'h0);
    check1("rst_done", done_o, 1'b0);
    check("rst_byte_addr", 64'(byte_addr_o), 64'h0);
    check1("rst_stall", stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 11; i++)
      do_access(vecs[i].wr, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].gd, vecs[i].rdl,
                vecs[i].sqq, vecs[i].sqr, vecs[i].emis, vecs[i].eaddr, vecs[i].ebe, vecs[i].ewd);

    // Async reset while a load waits for its response.
    @(negedge clk_i);
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_width_1h_i = 4'b0001; addr_i = 64'h55;
    @(posedge clk_i); @(negedge clk_i);
    valid_i = 1'b0; mem_rd_i = 1'b0; dmem_gnt_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #1;
    check1("resp_stall_before_rst", stall_o, 1'b1);
    check("resp_be_before_rst", 64'(dmem_be_o), 64'h20);
    rst_i = 1'b1;
    #1;
    check1("arst_req", dmem_req_o, 1'b0);
    check("arst_addr", dmem_addr_o, 64'h0);
    check("arst_be", 64'(dmem_be_o), 64'h0);
    check("arst_byte_addr", 64'(byte_addr_o), 64'h0);
    check1("arst_stall", stall_o, 1'b0);
    check1("arst_done", done_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0; dmem_rvalid_i = 1'b1;
    #1;
    check1("rvalid_after_rst_stall", stall_o, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    #1;
    check1("rvalid_after_rst_done", done_o, 1'b0);
    last_byte = 3'd0;

    // Randomized accesses against the model.
    for (int n = 0; n < 200; n++) begin
      bit wr;
      logic [3:0] w;
      logic [63:0] a, d;
      logic [2:0] mask;
      int s, gd, rdl, sqq, sqr;
      wr = 1'($urandom_range(0, 1));
      w = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) w = 4'($urandom_range(0, 15));
      a = {$urandom(), $urandom()};
      d = {$urandom(), $urandom()};
      s = size_of(w);
      if (s != 0 && $urandom_range(0, 3) != 0) begin
        mask = 3'(s - 1);
        a[2:0] = a[2:0] & ~mask;
      end
      gd = $urandom_range(0, 3);
      rdl = $urandom_range(0, 3);
      sqq = ($urandom_range(0, 4) == 0) ? $urandom_range(0, gd) : -1;
      sqr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rdl) : -1;
      do_access(wr, w, a, d, gd, rdl, sqq, sqr, model_mis(w, a),
                {a[63:3], 3'b000}, model_be(w, a), model_wd(wr, w, d));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk_i); @(negedge clk_i);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
